// File: rtl/vend_sequencer.sv
// Vending-machine transaction controller: coin credit, priced two-product selection,
// dispense handshake and change payout through the coin hopper.
module vend_sequencer #(
    parameter int PRICE_A    = 15,
    parameter int PRICE_B    = 20,
    parameter int MAX_CREDIT = 30,
    parameter int TIMEOUT    = 255,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          sel_valid,
    input  logic          sel,
    input  logic          cancel,
    output logic          disp_req,
    output logic          disp_sel,
    input  logic          disp_ack,
    output logic          pay_req,
    output logic [1:0]    pay_coin,
    input  logic          pay_ack,
    output logic [CW-1:0] credit,
    output logic          busy,
    output logic          coin_reject
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [CW:0]   MAX_CREDIT_W = (CW + 1)'(MAX_CREDIT);
    localparam logic [CW-1:0] PRICE_A_W    = CW'(PRICE_A);
    localparam logic [CW-1:0] PRICE_B_W    = CW'(PRICE_B);
    localparam logic [CW-1:0] FIVE_W       = CW'(5);
    localparam logic [CW-1:0] TEN_W        = CW'(10);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        PAYOUT   = 2'd3
    } state_t;

    state_t        state_r;
    logic [TW-1:0] tmo_r;
    logic [CW-1:0] credit_r;
    logic          disp_req_r;
    logic          disp_sel_r;
    logic          pay_req_r;
    logic [1:0]    pay_coin_r;
    logic          busy_r;
    logic          coin_reject_r;

    logic [CW-1:0] coin_val_s;
    logic          coin_ok_s;
    logic [CW:0]   sum_s;
    logic [CW-1:0] price_s;
    logic [CW-1:0] pay_val_s;
    logic          collecting_s;
    logic          sel_hit_s;
    logic          coin_accept_s;
    logic          coin_reject_s;

    // Decode the incoming coin pulse into a rupee value.
    always_comb begin
        coin_val_s = '0;
        coin_ok_s  = 1'b0;
        case (coin)
            2'b01: begin
                coin_val_s = FIVE_W;
                coin_ok_s  = 1'b1;
            end
            2'b10: begin
                coin_val_s = TEN_W;
                coin_ok_s  = 1'b1;
            end
            default: begin
                coin_val_s = '0;
                coin_ok_s  = 1'b0;
            end
        endcase
    end

    // Acceptance decisions; a coin loses to a same-cycle cancel or purchase.
    always_comb begin
        sum_s         = {1'b0, credit_r} + {1'b0, coin_val_s};
        price_s       = sel ? PRICE_B_W : PRICE_A_W;
        pay_val_s     = (pay_coin_r == 2'b10) ? TEN_W : FIVE_W;
        collecting_s  = (state_r == COLLECT);
        sel_hit_s     = collecting_s && sel_valid && !cancel && (credit_r >= price_s);
        coin_accept_s = ((state_r == IDLE) || collecting_s) && coin_ok_s &&
                        (sum_s <= MAX_CREDIT_W) && !(collecting_s && cancel) && !sel_hit_s;
        coin_reject_s = (coin != 2'b00) && !coin_accept_s;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            tmo_r         <= '0;
            credit_r      <= '0;
            disp_req_r    <= 1'b0;
            disp_sel_r    <= 1'b0;
            pay_req_r     <= 1'b0;
            pay_coin_r    <= 2'b00;
            busy_r        <= 1'b0;
            coin_reject_r <= 1'b0;
        end else begin
            coin_reject_r <= coin_reject_s;
            case (state_r)
                IDLE: begin
                    tmo_r <= '0;
                    if (coin_accept_s) begin
                        credit_r <= sum_s[CW-1:0];
                        state_r  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        tmo_r   <= '0;
                        state_r <= PAYOUT;
                        busy_r  <= 1'b1;
                    end else if (sel_hit_s) begin
                        tmo_r      <= '0;
                        credit_r   <= credit_r - price_s;
                        disp_sel_r <= sel;
                        disp_req_r <= 1'b1;
                        state_r    <= DISPENSE;
                        busy_r     <= 1'b1;
                    end else begin
                        if (coin_accept_s) begin
                            credit_r <= sum_s[CW-1:0];
                        end
                        if (coin_accept_s || sel_valid) begin
                            tmo_r <= '0;
                        end else if (tmo_r == TMO_LAST) begin
                            tmo_r   <= '0;
                            state_r <= PAYOUT;
                            busy_r  <= 1'b1;
                        end else begin
                            tmo_r <= tmo_r + TW'(1);
                        end
                    end
                end
                DISPENSE: begin
                    tmo_r <= '0;
                    if (disp_req_r && disp_ack) begin
                        disp_req_r <= 1'b0;
                        if (credit_r != '0) begin
                            state_r <= PAYOUT;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                PAYOUT: begin
                    tmo_r <= '0;
                    if (pay_req_r) begin
                        if (pay_ack) begin
                            pay_req_r  <= 1'b0;
                            pay_coin_r <= 2'b00;
                            // Clamp so a short credit can never wrap below zero.
                            if (credit_r <= pay_val_s) begin
                                credit_r <= '0;
                                state_r  <= IDLE;
                                busy_r   <= 1'b0;
                            end else begin
                                credit_r <= credit_r - pay_val_s;
                            end
                        end
                    end else if (credit_r != '0) begin
                        pay_req_r  <= 1'b1;
                        pay_coin_r <= (credit_r >= TEN_W) ? 2'b10 : 2'b01;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tmo_r      <= '0;
                    credit_r   <= '0;
                    disp_req_r <= 1'b0;
                    pay_req_r  <= 1'b0;
                    pay_coin_r <= 2'b00;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign disp_req    = disp_req_r;
    assign disp_sel    = disp_sel_r;
    assign pay_req     = pay_req_r;
    assign pay_coin    = pay_coin_r;
    assign credit      = credit_r;
    assign busy        = busy_r;
    assign coin_reject = coin_reject_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: expected dispenses and payouts are queued
// when stimulus is driven and compared when the actuator requests appear.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin;
    logic       sel_valid;
    logic       sel;
    logic       cancel;
    logic       disp_req;
    logic       disp_sel;
    logic       disp_ack;
    logic       pay_req;
    logic [1:0] pay_coin;
    logic       pay_ack;
    logic [5:0] credit;
    logic       busy;
    logic       coin_reject;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int coin;
        int credit_after;
    } pay_t;

    pay_t pay_q[$];
    int   disp_q[$];

    vend_sequencer dut (
        .clk(clk), .rst(rst), .coin(coin), .sel_valid(sel_valid), .sel(sel),
        .cancel(cancel), .disp_req(disp_req), .disp_sel(disp_sel), .disp_ack(disp_ack),
        .pay_req(pay_req), .pay_coin(pay_coin), .pay_ack(pay_ack), .credit(credit),
        .busy(busy), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin = c;
        tick();
        coin = 2'b00;
    endtask

    task automatic push_pay(input int c, input int after);
        pay_t p;
        p.coin = c;
        p.credit_after = after;
        pay_q.push_back(p);
    endtask

    task automatic serve_disp();
        int n = 0;
        int e = -1;
        while (!disp_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("disp_req_wait", int'(disp_req), 1);
        if (disp_q.size() > 0) e = disp_q.pop_front();
        check_eq("disp_sel", int'(disp_sel), e);
        repeat (2) tick();
        check_eq("disp_hold", int'(disp_req), 1);
        check_eq("disp_sel_stable", int'(disp_sel), e);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check_eq("disp_drop", int'(disp_req), 0);
    endtask

    task automatic serve_pay(input bit check_gap);
        int   n = 0;
        pay_t e;
        e.coin = 0;
        e.credit_after = 63;
        while (!pay_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("pay_req_wait", int'(pay_req), 1);
        if (check_gap) check_eq("pay_gap", n, 1);
        if (pay_q.size() > 0) e = pay_q.pop_front();
        check_eq("pay_coin", int'(pay_coin), e.coin);
        tick();
        check_eq("pay_hold", int'(pay_req), 1);
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
        check_eq("pay_drop", int'(pay_req), 0);
        check_eq("pay_credit", int'(credit), e.credit_after);
    endtask

    initial begin
        rst = 1'b1; coin = 2'b00; sel_valid = 1'b0; sel = 1'b0; cancel = 1'b0;
        disp_ack = 1'b0; pay_ack = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_credit", int'(credit), 0);
        check_eq("rst_disp_req", int'(disp_req), 0);
        check_eq("rst_pay_req", int'(pay_req), 0);
        check_eq("rst_pay_coin", int'(pay_coin), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_reject", int'(coin_reject), 0);

        // 5 + 10, buy A exactly: no change.
        put_coin(2'b01);
        check_eq("s1_credit5", int'(credit), 5);
        put_coin(2'b10);
        check_eq("s1_credit15", int'(credit), 15);
        sel = 1'b0; sel_valid = 1'b1; disp_q.push_back(0);
        tick();
        sel_valid = 1'b0;
        check_eq("s1_credit0", int'(credit), 0);
        check_eq("s1_busy", int'(busy), 1);
        serve_disp();
        check_eq("s1_idle", int'(busy), 0);
        repeat (3) tick();
        check_eq("s1_no_pay", int'(pay_req), 0);

        // 10 + 10, buy A: one 5 coin change.
        put_coin(2'b10);
        put_coin(2'b10);
        check_eq("s2_credit20", int'(credit), 20);
        sel = 1'b0; sel_valid = 1'b1; disp_q.push_back(0); push_pay(1, 0);
        tick();
        sel_valid = 1'b0;
        check_eq("s2_credit5", int'(credit), 5);
        serve_disp();
        check_eq("s2_busy_payout", int'(busy), 1);
        serve_pay(1'b0);
        check_eq("s2_idle", int'(busy), 0);

        // 10 + 10 + 5, cancel: refund 10, 10, 5.
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b01);
        check_eq("s3_credit25", int'(credit), 25);
        cancel = 1'b1; push_pay(2, 15); push_pay(2, 5); push_pay(1, 0);
        tick();
        cancel = 1'b0;
        check_eq("s3_busy", int'(busy), 1);
        serve_pay(1'b0);
        serve_pay(1'b1);
        serve_pay(1'b1);
        check_eq("s3_idle", int'(busy), 0);

        // Credit ceiling, invalid coin, coin during payout.
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b10);
        check_eq("s4_credit30", int'(credit), 30);
        check_eq("s4_no_reject", int'(coin_reject), 0);
        put_coin(2'b01);
        check_eq("s4_over_reject", int'(coin_reject), 1);
        check_eq("s4_over_credit", int'(credit), 30);
        tick();
        check_eq("s4_reject_pulse", int'(coin_reject), 0);
        put_coin(2'b11);
        check_eq("s4_bad_reject", int'(coin_reject), 1);
        check_eq("s4_bad_credit", int'(credit), 30);
        cancel = 1'b1; push_pay(2, 20); push_pay(2, 10); push_pay(2, 0);
        tick();
        cancel = 1'b0;
        put_coin(2'b01);
        check_eq("s4_payout_reject", int'(coin_reject), 1);
        serve_pay(1'b0);
        serve_pay(1'b1);
        serve_pay(1'b1);
        check_eq("s4_idle", int'(busy), 0);

        // Idle timeout refunds a single 5.
        put_coin(2'b01);
        repeat (254) tick();
        check_eq("s5_before_tmo", int'(busy), 0);
        tick();
        check_eq("s5_tmo", int'(busy), 1);
        push_pay(1, 0);
        serve_pay(1'b0);

        // Unaffordable B selection is ignored but restarts the timeout.
        put_coin(2'b10);
        put_coin(2'b01);
        repeat (100) tick();
        sel = 1'b1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check_eq("s5_sel_ignored", int'(disp_req), 0);
        check_eq("s5_sel_credit", int'(credit), 15);
        repeat (254) tick();
        check_eq("s5_tmo_cleared", int'(busy), 0);
        tick();
        check_eq("s5_tmo2", int'(busy), 1);
        push_pay(2, 5); push_pay(1, 0);
        serve_pay(1'b0);
        serve_pay(1'b1);

        // Reset during dispense drops credit with no payout.
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b10);
        sel = 1'b1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check_eq("s6_disp_req", int'(disp_req), 1);
        check_eq("s6_disp_sel", int'(disp_sel), 1);
        check_eq("s6_credit10", int'(credit), 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("s6_rst_credit", int'(credit), 0);
        check_eq("s6_rst_disp_req", int'(disp_req), 0);
        check_eq("s6_rst_disp_sel", int'(disp_sel), 0);
        check_eq("s6_rst_busy", int'(busy), 0);
        repeat (4) tick();
        check_eq("s6_no_pay", int'(pay_req), 0);
        check_eq("s6_credit_stays0", int'(credit), 0);

        check_eq("scoreboard_left", pay_q.size() + disp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
